// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter: bus widths, FSM encoding and the
// frame-buffer pixel addressing helper.
package sram_pkg;

    localparam int SRAM_AW      = 20;
    localparam int SRAM_DW      = 16;
    localparam int PIXEL_COLUMN = 640;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DISP_RD  = 3'd1,
        S_ACC_RD   = 3'd2,
        S_ACC_WAIT = 3'd3,
        S_ACC_WR   = 3'd4,
        S_TURN     = 3'd5
    } arb_state_t;

    // Pixel (x, y) lives at 640*x + y in the frame buffer.
    function automatic logic [SRAM_AW-1:0] pixel_addr(input logic [SRAM_AW-1:0] x,
                                                       input logic [SRAM_AW-1:0] y);
        return x * SRAM_AW'(PIXEL_COLUMN) + y;
    endfunction

endpackage

// File: rtl/sram_phy.sv
// Pin-side register stage for the async SRAM: registered strobes and address,
// write-word register with tristate DQ driver, and read-capture register.
module sram_phy
    import sram_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_n_next,
    input  logic               oe_n_next,
    input  logic               we_n_next,
    input  logic               drive_next,
    input  logic               addr_load,
    input  logic [SRAM_AW-1:0] addr_next,
    input  logic               wr_load,
    input  logic [SRAM_DW-1:0] wr_next,
    input  logic               capture,
    output logic [SRAM_DW-1:0] rd_data,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               ce_n,
    output logic               oe_n,
    output logic               we_n,
    output logic               lb_n,
    output logic               ub_n
);

    logic               drive;
    logic [SRAM_DW-1:0] wr_q;

    // Byte lanes idle high only while reset is held; otherwise both lanes are always enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_n      <= 1'b1;
            oe_n      <= 1'b1;
            we_n      <= 1'b1;
            lb_n      <= 1'b1;
            ub_n      <= 1'b1;
            drive     <= 1'b0;
            sram_addr <= '0;
            wr_q      <= '0;
            rd_data   <= '0;
        end else begin
            ce_n  <= ce_n_next;
            oe_n  <= oe_n_next;
            we_n  <= we_n_next;
            lb_n  <= 1'b0;
            ub_n  <= 1'b0;
            drive <= drive_next;
            if (addr_load) begin
                sram_addr <= addr_next;
            end
            if (wr_load) begin
                wr_q <= wr_next;
            end
            if (capture) begin
                rd_data <= sram_dq;
            end
        end
    end

    assign sram_dq = drive ? wr_q : 'z;

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the single-port SRAM between display scan-out reads and atomic
// accumulator read-modify-write sequences, with a bounded display run length.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int DISP_MAX_RUN = 8,
    parameter int MOD_LAT      = 1
) (
    input  logic               i_50M_clk,
    input  logic               i_rst,
    input  logic               i_disp_req,
    input  logic [SRAM_AW-1:0] i_disp_addr,
    output logic               o_disp_gnt,
    output logic               o_disp_valid,
    output logic [SRAM_DW-1:0] o_disp_data,
    input  logic               i_acc_req,
    input  logic [SRAM_AW-1:0] i_acc_addr,
    output logic               o_acc_gnt,
    output logic               o_acc_rd_valid,
    output logic [SRAM_DW-1:0] o_acc_rd_data,
    input  logic [SRAM_DW-1:0] i_acc_wr_data,
    output logic               o_acc_done,
    output logic [SRAM_AW-1:0] o_SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N
);

    localparam int RUN_W  = $clog2(DISP_MAX_RUN + 1);
    localparam int WAIT_W = $clog2(MOD_LAT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(DISP_MAX_RUN);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MOD_LAT - 1);

    arb_state_t         state;
    arb_state_t         state_next;
    logic [RUN_W-1:0]   run_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               disp_pick;
    logic               wait_last;
    logic               ce_n_next;
    logic               oe_n_next;
    logic               we_n_next;
    logic               drive_next;
    logic               disp_gnt_next;
    logic               acc_gnt_next;
    logic               done_next;
    logic [SRAM_DW-1:0] rd_data;

    // Display wins unless the accumulator is waiting and the display has used up its run.
    assign disp_pick = i_disp_req && (!i_acc_req || (run_cnt < RUN_MAX));
    assign wait_last = (wait_cnt == WAIT_LAST);

    always_ff @(posedge i_50M_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            run_cnt        <= '0;
            wait_cnt       <= '0;
            o_disp_gnt     <= 1'b0;
            o_disp_valid   <= 1'b0;
            o_acc_gnt      <= 1'b0;
            o_acc_rd_valid <= 1'b0;
            o_acc_done     <= 1'b0;
        end else begin
            state <= state_next;
            if (!i_acc_req || (state_next == S_ACC_RD)) begin
                run_cnt <= '0;
            end else if ((state_next == S_DISP_RD) && (run_cnt != RUN_MAX)) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if ((state == S_ACC_WAIT) && !wait_last) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            o_disp_gnt     <= disp_gnt_next;
            o_acc_gnt      <= acc_gnt_next;
            o_acc_done     <= done_next;
            o_disp_valid   <= (state == S_DISP_RD);
            o_acc_rd_valid <= (state == S_ACC_RD);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DISP_RD, S_TURN: begin
                if (disp_pick) begin
                    state_next = S_DISP_RD;
                end else if (i_acc_req) begin
                    state_next = S_ACC_RD;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_ACC_RD:   state_next = S_ACC_WAIT;
            S_ACC_WAIT: state_next = wait_last ? S_ACC_WR : S_ACC_WAIT;
            S_ACC_WR:   state_next = S_TURN;
            default:    state_next = S_IDLE;
        endcase
    end

    // Pin-side values are decoded from the upcoming state so they line up with it once registered.
    always_comb begin
        ce_n_next     = 1'b1;
        oe_n_next     = 1'b1;
        we_n_next     = 1'b1;
        drive_next    = 1'b0;
        disp_gnt_next = 1'b0;
        acc_gnt_next  = 1'b0;
        done_next     = 1'b0;
        case (state_next)
            S_DISP_RD: begin
                ce_n_next     = 1'b0;
                oe_n_next     = 1'b0;
                disp_gnt_next = 1'b1;
            end
            S_ACC_RD: begin
                ce_n_next    = 1'b0;
                oe_n_next    = 1'b0;
                acc_gnt_next = 1'b1;
            end
            S_ACC_WAIT: begin
                ce_n_next = 1'b0;
            end
            S_ACC_WR: begin
                ce_n_next  = 1'b0;
                we_n_next  = 1'b0;
                drive_next = 1'b1;
            end
            S_TURN: begin
                ce_n_next  = 1'b0;
                drive_next = 1'b1;
                done_next  = 1'b1;
            end
            default: begin
                ce_n_next = 1'b1;
            end
        endcase
    end

    sram_phy u_phy (
        .clk        (i_50M_clk),
        .rst        (i_rst),
        .ce_n_next  (ce_n_next),
        .oe_n_next  (oe_n_next),
        .we_n_next  (we_n_next),
        .drive_next (drive_next),
        .addr_load  ((state_next == S_DISP_RD) || (state_next == S_ACC_RD)),
        .addr_next  ((state_next == S_DISP_RD) ? i_disp_addr : i_acc_addr),
        .wr_load    ((state == S_ACC_WAIT) && wait_last),
        .wr_next    (i_acc_wr_data),
        .capture    ((state == S_DISP_RD) || (state == S_ACC_RD)),
        .rd_data    (rd_data),
        .sram_addr  (o_SRAM_ADDR),
        .sram_dq    (io_SRAM_DQ),
        .ce_n       (o_SRAM_CE_N),
        .oe_n       (o_SRAM_OE_N),
        .we_n       (o_SRAM_WE_N),
        .lb_n       (o_SRAM_LB_N),
        .ub_n       (o_SRAM_UB_N)
    );

    assign o_disp_data   = rd_data;
    assign o_acc_rd_data = rd_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench: two arbiters (MOD_LAT=1 and MOD_LAT=3), each on its own
// behavioural async SRAM, with read data checked through scoreboard queues.
module tb_sram_arbiter;
    import sram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        disp_req, acc_req;
    logic [19:0] disp_addr, acc_addr;
    logic        disp_gnt, disp_valid, acc_gnt, acc_rd_valid, acc_done;
    logic [15:0] disp_data, acc_rd_data, acc_wr_data;
    logic [19:0] sram_addr0;
    wire  [15:0] sram_dq0;
    logic        ce0, oe0, we0, lb0, ub0;

    logic        disp_req1, acc_req1;
    logic [19:0] disp_addr1, acc_addr1;
    logic        disp_gnt1, disp_valid1, acc_gnt1, acc_rd_valid1, acc_done1;
    logic [15:0] disp_data1, acc_rd_data1, acc_wr_data1;
    logic [19:0] sram_addr1;
    wire  [15:0] sram_dq1;
    logic        ce1, oe1, we1, lb1, ub1;

    // The accumulator on the first arbiter forms its write word straight from the read word.
    assign acc_wr_data = acc_rd_data + 16'h0004;

    sram_arbiter #(.DISP_MAX_RUN(8), .MOD_LAT(1)) u_dut0 (
        .i_50M_clk(clk), .i_rst(rst),
        .i_disp_req(disp_req), .i_disp_addr(disp_addr), .o_disp_gnt(disp_gnt),
        .o_disp_valid(disp_valid), .o_disp_data(disp_data),
        .i_acc_req(acc_req), .i_acc_addr(acc_addr), .o_acc_gnt(acc_gnt),
        .o_acc_rd_valid(acc_rd_valid), .o_acc_rd_data(acc_rd_data),
        .i_acc_wr_data(acc_wr_data), .o_acc_done(acc_done),
        .o_SRAM_ADDR(sram_addr0), .io_SRAM_DQ(sram_dq0),
        .o_SRAM_CE_N(ce0), .o_SRAM_OE_N(oe0), .o_SRAM_WE_N(we0),
        .o_SRAM_LB_N(lb0), .o_SRAM_UB_N(ub0)
    );

    sram_arbiter #(.DISP_MAX_RUN(8), .MOD_LAT(3)) u_dut1 (
        .i_50M_clk(clk), .i_rst(rst),
        .i_disp_req(disp_req1), .i_disp_addr(disp_addr1), .o_disp_gnt(disp_gnt1),
        .o_disp_valid(disp_valid1), .o_disp_data(disp_data1),
        .i_acc_req(acc_req1), .i_acc_addr(acc_addr1), .o_acc_gnt(acc_gnt1),
        .o_acc_rd_valid(acc_rd_valid1), .o_acc_rd_data(acc_rd_data1),
        .i_acc_wr_data(acc_wr_data1), .o_acc_done(acc_done1),
        .o_SRAM_ADDR(sram_addr1), .io_SRAM_DQ(sram_dq1),
        .o_SRAM_CE_N(ce1), .o_SRAM_OE_N(oe1), .o_SRAM_WE_N(we1),
        .o_SRAM_LB_N(lb1), .o_SRAM_UB_N(ub1)
    );

    // Behavioural async SRAMs, aliased to 4K words; a preload port avoids a second writer.
    logic [15:0] mem0 [0:4095];
    logic [15:0] mem1 [0:4095];
    logic        pre_en, pre_sel;
    logic [11:0] pre_addr;
    logic [15:0] pre_data;
    logic        dq0_en, dq1_en;
    logic [15:0] dq0_drv, dq1_drv;
    int          we_low0 = 0;
    int          done_cnt0 = 0;

    always_comb begin
        dq0_en  = !ce0 && !oe0 && we0;
        dq0_drv = mem0[sram_addr0[11:0]];
        dq1_en  = !ce1 && !oe1 && we1;
        dq1_drv = mem1[sram_addr1[11:0]];
    end
    assign sram_dq0 = dq0_en ? dq0_drv : 'z;
    assign sram_dq1 = dq1_en ? dq1_drv : 'z;

    always @(posedge clk) begin
        if (pre_en && !pre_sel) begin
            mem0[pre_addr] <= pre_data;
        end else if (!ce0 && !we0) begin
            mem0[sram_addr0[11:0]] <= sram_dq0;
            we_low0 <= we_low0 + 1;
        end
        if (pre_en && pre_sel) begin
            mem1[pre_addr] <= pre_data;
        end else if (!ce1 && !we1) begin
            mem1[sram_addr1[11:0]] <= sram_dq1;
        end
    end

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic d_req, input logic [19:0] d_addr,
                                 input logic a_req, input logic [19:0] a_addr);
        disp_req  = d_req;
        disp_addr = d_addr;
        acc_req   = a_req;
        acc_addr  = a_addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic sel, input logic [11:0] a, input logic [15:0] d);
        pre_sel  = sel;
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    logic [15:0] disp_q[$];
    logic [15:0] acc_q[$];
    logic [15:0] acc1_q[$];

    always @(negedge clk) begin
        if (acc_done) done_cnt0 <= done_cnt0 + 1;
        if (disp_valid) begin
            if (disp_q.size() == 0) checkOutput("disp_valid_unexpected", 32'(disp_valid), 32'd0);
            else                    checkOutput("disp_data", 32'(disp_data), 32'(disp_q.pop_front()));
        end
        if (acc_rd_valid) begin
            if (acc_q.size() == 0) checkOutput("acc_rd_valid_unexpected", 32'(acc_rd_valid), 32'd0);
            else                   checkOutput("acc_rd_data", 32'(acc_rd_data), 32'(acc_q.pop_front()));
        end
        if (acc_rd_valid1) begin
            if (acc1_q.size() == 0) checkOutput("acc1_rd_valid_unexpected", 32'(acc_rd_valid1), 32'd0);
            else                    checkOutput("acc1_rd_data", 32'(acc_rd_data1), 32'(acc1_q.pop_front()));
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [19:0] pix;
        logic [15:0] acc_exp;
        int          n, w_before, d_before, ph;
        logic        got, done_seen;

        pix = pixel_addr(20'd3, 20'd5);
        rst = 1'b1;
        pre_en = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_data = '0;
        applyStimulus(1'b0, 20'd0, 1'b0, 20'd0);
        disp_req1 = 1'b0; disp_addr1 = '0; acc_req1 = 1'b0; acc_addr1 = '0; acc_wr_data1 = '0;

        preload(1'b0, 12'd0, 16'h1234);
        preload(1'b0, 12'd1, 16'h5678);
        preload(1'b0, pix[11:0], 16'h0100);
        preload(1'b1, pix[11:0], 16'h0100);

        $display("[TB] reset state");
        checkOutput("rst_ce_n", 32'(ce0), 32'd1);
        checkOutput("rst_oe_n", 32'(oe0), 32'd1);
        checkOutput("rst_we_n", 32'(we0), 32'd1);
        checkOutput("rst_lb_n", 32'(lb0), 32'd1);
        checkOutput("rst_ub_n", 32'(ub0), 32'd1);
        checkOutput("rst_addr", 32'(sram_addr0), 32'd0);
        checkOutput("rst_gnts", {30'd0, disp_gnt, acc_gnt}, 32'd0);
        checkOutput("rst_valids_done", {29'd0, disp_valid, acc_rd_valid, acc_done}, 32'd0);
        checkOutput("rst_data", {disp_data, acc_rd_data}, 32'd0);

        rst = 1'b0;
        tick();
        tick();
        checkOutput("idle_ce_n", 32'(ce0), 32'd1);
        checkOutput("idle_we_n", 32'(we0), 32'd1);
        checkOutput("idle_lb_ub", {30'd0, lb0, ub0}, 32'd0);
        checkOutput("idle_gnts", {30'd0, disp_gnt, acc_gnt}, 32'd0);

        $display("[TB] display back-to-back reads");
        applyStimulus(1'b1, 20'd0, 1'b0, 20'd0);
        disp_q.push_back(16'h1234);
        tick();
        checkOutput("disp_gnt_first", 32'(disp_gnt), 32'd1);
        checkOutput("disp_oe_n_rd", 32'(oe0), 32'd0);
        checkOutput("disp_valid_before", 32'(disp_valid), 32'd0);
        applyStimulus(1'b1, 20'd1, 1'b0, 20'd0);
        disp_q.push_back(16'h5678);
        tick();
        checkOutput("disp_gnt_second", 32'(disp_gnt), 32'd1);
        checkOutput("disp_valid_first", 32'(disp_valid), 32'd1);
        checkOutput("disp_addr_second", 32'(sram_addr0), 32'd1);
        applyStimulus(1'b0, 20'd0, 1'b0, 20'd0);
        tick();
        checkOutput("disp_gnt_drop", 32'(disp_gnt), 32'd0);
        checkOutput("disp_valid_second", 32'(disp_valid), 32'd1);
        tick();
        checkOutput("disp_valid_end", 32'(disp_valid), 32'd0);
        checkOutput("disp_idle_ce_n", 32'(ce0), 32'd1);

        $display("[TB] accumulator read-modify-write");
        w_before = we_low0;
        applyStimulus(1'b0, 20'd0, 1'b1, pix);
        acc_q.push_back(16'h0100);
        tick();
        checkOutput("acc_gnt", 32'(acc_gnt), 32'd1);
        checkOutput("acc_addr_rd", 32'(sram_addr0), 32'd1925);
        applyStimulus(1'b0, 20'd0, 1'b0, 20'd0);
        n = 0; got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            n++;
            if (acc_done) got = 1'b1;
        end
        // Done lands in the 4th occupied cycle, i.e. three clocks after the grant cycle.
        checkOutput("acc_done_seen", 32'(got), 32'd1);
        checkOutput("acc_done_latency", 32'(n), 32'd3);
        checkOutput("acc_we_pulses", 32'(we_low0 - w_before), 32'd1);
        checkOutput("acc_mem_1925", 32'(mem0[pix[11:0]]), 32'h0104);
        tick();
        checkOutput("acc_done_pulse", 32'(acc_done), 32'd0);
        checkOutput("acc_idle_ce_n", 32'(ce0), 32'd1);

        $display("[TB] both requesters continuous");
        acc_exp = 16'h0104;
        applyStimulus(1'b1, 20'd0, 1'b1, pix);
        for (int c = 1; c <= 36; c++) begin
            tick();
            ph = (c - 1) % 12;
            checkOutput("fair_disp_gnt", 32'(disp_gnt), 32'(ph < 8));
            checkOutput("fair_acc_gnt", 32'(acc_gnt), 32'(ph == 8));
            if (disp_gnt) disp_q.push_back(16'h1234);
            if (acc_gnt) begin
                acc_q.push_back(acc_exp);
                acc_exp = acc_exp + 16'h0004;
            end
            if (c == 36) applyStimulus(1'b0, 20'd0, 1'b0, 20'd0);
        end
        tick();
        tick();
        checkOutput("fair_mem_1925", 32'(mem0[pix[11:0]]), 32'h0110);

        $display("[TB] display request during RMW wait");
        applyStimulus(1'b0, 20'd0, 1'b1, pix);
        acc_q.push_back(16'h0110);
        tick();
        checkOutput("turn_acc_gnt", 32'(acc_gnt), 32'd1);
        applyStimulus(1'b0, 20'd0, 1'b0, 20'd0);
        tick();
        applyStimulus(1'b1, 20'd1, 1'b0, 20'd0);
        disp_q.push_back(16'h5678);
        n = 0; got = 1'b0; done_seen = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            n++;
            if (acc_done) done_seen = 1'b1;
            if (disp_gnt) got = 1'b1;
        end
        checkOutput("turn_disp_granted", 32'(got), 32'd1);
        checkOutput("turn_disp_wait", 32'(n), 32'd3);
        checkOutput("turn_done_first", 32'(done_seen), 32'd1);
        applyStimulus(1'b0, 20'd0, 1'b0, 20'd0);
        tick();
        tick();
        checkOutput("turn_mem_1925", 32'(mem0[pix[11:0]]), 32'h0114);

        $display("[TB] reset in the middle of an RMW");
        applyStimulus(1'b0, 20'd0, 1'b1, pix);
        acc_q.push_back(16'h0114);
        tick();
        applyStimulus(1'b0, 20'd0, 1'b0, 20'd0);
        w_before = we_low0;
        d_before = done_cnt0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rstmid_we_n", 32'(we0), 32'd1);
        checkOutput("rstmid_ce_n", 32'(ce0), 32'd1);
        rst = 1'b0;
        tick();
        tick();
        checkOutput("rstmid_no_write", 32'(we_low0 - w_before), 32'd0);
        checkOutput("rstmid_no_done", 32'(done_cnt0 - d_before), 32'd0);
        checkOutput("rstmid_mem_1925", 32'(mem0[pix[11:0]]), 32'h0114);

        $display("[TB] MOD_LAT=3 write-data sampling");
        acc_req1 = 1'b1;
        acc_addr1 = pix;
        acc1_q.push_back(16'h0100);
        tick();
        checkOutput("m3_gnt", 32'(acc_gnt1), 32'd1);
        acc_req1 = 1'b0;
        acc_wr_data1 = 16'h1111;
        tick();
        checkOutput("m3_rd_valid_w1", 32'(acc_rd_valid1), 32'd1);
        acc_wr_data1 = 16'hAAAA;
        tick();
        checkOutput("m3_rd_valid_w2", 32'(acc_rd_valid1), 32'd0);
        checkOutput("m3_we_n_w2", 32'(we1), 32'd1);
        acc_wr_data1 = 16'hBBBB;
        tick();
        checkOutput("m3_rd_data_hold", 32'(acc_rd_data1), 32'h0100);
        acc_wr_data1 = 16'h0777;
        tick();
        checkOutput("m3_we_n_wr", 32'(we1), 32'd0);
        checkOutput("m3_dq_wr", 32'(sram_dq1), 32'h0777);
        acc_wr_data1 = 16'hDEAD;
        tick();
        checkOutput("m3_done", 32'(acc_done1), 32'd1);
        checkOutput("m3_we_n_turn", 32'(we1), 32'd1);
        checkOutput("m3_mem_1925", 32'(mem1[pix[11:0]]), 32'h0777);
        tick();
        checkOutput("m3_idle_ce_n", 32'(ce1), 32'd1);

        tick();
        checkOutput("disp_q_drained", 32'(disp_q.size()), 32'd0);
        checkOutput("acc_q_drained", 32'(acc_q.size()), 32'd0);
        checkOutput("acc1_q_drained", 32'(acc1_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port SRAM arbiter and sequencer sharing the off-chip 1M×16 asynchronous SRAM between the frame-averaging engine (atomic read-modify-write per pixel) and the display scan-out (read-only). Sits between those requesters and the SRAM pins, owns every SRAM control strobe, and guarantees bounded display latency without starving the averaging engine.

## Interface
- `DISP_MAX_RUN`, default 8: maximum consecutive display grants while an accumulator request is pending.
- `MOD_LAT`, default 1: number of ACC_WAIT cycles (≥1) between read-data return and write-data sampling.
- `i_50M_clk` in 1: system clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_disp_req` in 1: display read request; held until granted.
- `i_disp_addr` in 20: display read address; stable while `i_disp_req`.
- `o_disp_gnt` out 1: display address accepted this cycle.
- `o_disp_valid` out 1: `o_disp_data` valid.
- `o_disp_data` out 16: display read data.
- `i_acc_req` in 1: accumulator RMW request; held until granted.
- `i_acc_addr` in 20: RMW address, pixel address `640*x + y`.
- `o_acc_gnt` out 1: RMW read phase active.
- `o_acc_rd_valid` out 1: `o_acc_rd_data` valid.
- `o_acc_rd_data` out 16: old SRAM word.
- `i_acc_wr_data` in 16: new word; sampled in the last ACC_WAIT cycle.
- `o_acc_done` out 1: RMW write completed (1-cycle pulse).
- `o_SRAM_ADDR` out 20; `io_SRAM_DQ` inout 16.
- `o_SRAM_CE_N`, `o_SRAM_OE_N`, `o_SRAM_WE_N`, `o_SRAM_LB_N`, `o_SRAM_UB_N` out 1 each, active-low.

## Operation
- States: S_IDLE, S_DISP_RD, S_ACC_RD, S_ACC_WAIT, S_ACC_WR, S_TURN.
- Decision points: S_IDLE, S_DISP_RD, S_TURN. At each point:
  - If `i_disp_req` and (not `i_acc_req` or `run_cnt < DISP_MAX_RUN`): go to S_DISP_RD.
  - Else if `i_acc_req`: go to S_ACC_RD.
  - Else: go to S_IDLE.
- `run_cnt`, width `$clog2(DISP_MAX_RUN+1)`:
  - Increments on each DISP_RD entry while `i_acc_req` is high; saturates.
  - Clears on S_ACC_RD entry, and whenever `i_acc_req` is low.
- RMW is atomic: S_ACC_RD → S_ACC_WAIT (MOD_LAT cycles) → S_ACC_WR → S_TURN. No display grant is issued inside the sequence.
- The RMW address is registered on S_ACC_RD entry and held through S_ACC_WR.
- Arithmetic: pass-through only, no modification of data.
- Strobes:
  - LB_N and UB_N are always 0.
  - CE_N is 0 in every non-IDLE state.
  - OE_N is 0 in DISP_RD and ACC_RD.
  - WE_N is 0 only in ACC_WR.
- DQ is driven in ACC_WR and TURN with the registered write word, and high-Z otherwise.
- Reset (also mid-operation): state returns to S_IDLE and `run_cnt` clears.
  - All `_N` strobes go to 1, `o_SRAM_ADDR` to 0, DQ to high-Z.
  - All `o_*` valids, grants and `o_acc_done` go to 0; data outputs go to 0.
  - An in-flight RMW is dropped without a write and without a done pulse.

## Timing
- All SRAM outputs, grants, valids and data outputs are registered; there is no combinational path from inputs to pins.
- Display read:
  - `o_disp_gnt` is high for the S_DISP_RD cycle.
  - DQ is captured at the end of that cycle.
  - `o_disp_valid`/`o_disp_data` appear the next cycle: 1-cycle latency from grant.
  - Back-to-back reads give 1 word per cycle.
- RMW:
  - `o_acc_gnt` is high in S_ACC_RD.
  - `o_acc_rd_valid` is high in the first ACC_WAIT cycle.
  - `i_acc_wr_data` is sampled in the last ACC_WAIT cycle; with MOD_LAT=1 this is the same cycle, so the requester may form write data combinationally from `o_acc_rd_data`.
  - The write occurs in S_ACC_WR; `o_acc_done` pulses in S_TURN.
  - Total occupancy: 3 + MOD_LAT cycles.
- S_TURN keeps DQ driven with WE_N high, giving address/data hold after the write; DQ releases on exit.
- Requesters drop `req` the cycle after seeing their grant or done; a request still high is treated as a new request.
- Worst-case display wait when the RMW has just started: 3 + MOD_LAT cycles.

## Structure
- Shared package `sram_pkg`:
  - `SRAM_AW=20`, `SRAM_DW=16`.
  - `typedef enum logic [2:0]` for the arbiter state.
  - The pixel-address helper constant `PIXEL_COLUMN`-based stride (640).
- Sub-module `sram_phy`: tristate DQ driver, registered strobes and read-capture register. The arbiter FSM drives it.

## Test plan
- Reset, then idle → all `_N` = 1, DQ high-Z, no grants; `i_rst` asserted mid-RMW → no WE_N low pulse, no `o_acc_done`.
- Display only, addr 0x00000 then 0x00001 back-to-back, SRAM model holding 0x1234/0x5678 → `o_disp_gnt` on 2 consecutive cycles, `o_disp_data` 0x1234 then 0x5678 one cycle later each.
- Acc only, addr 640*3+5=1925, SRAM holds 0x0100, `wr_data = rd_data + 4` → `rd_valid` with 0x0100; WE_N low exactly 1 cycle; SRAM[1925] = 0x0104; done at cycle 4 after grant (MOD_LAT=1).
- Both requesting in IDLE continuously, DISP_MAX_RUN=8 → 8 display grants, then 1 RMW, repeating; the accumulator is never starved.
- `i_disp_req` arriving during ACC_WAIT → no `o_disp_gnt` until S_TURN has passed; the display is granted at the first decision point, within 4 cycles.
- MOD_LAT=3 → `i_acc_wr_data` changed in the first 2 wait cycles is ignored; the value in cycle 3 is written.
